hex_word_sequencer: RTL
=======================

# hex_word_sequencer

Sequencing controller for the six-digit word display driven by the U/P/C item decoder. It selects which 3-bit code the combinational word decoder evaluates, captures the six returned glyphs, and scrolls them right-to-left across HEX5..HEX0. It supports a manual mode, where the code comes from the switches, and an auto mode, where it cycles through every defined code. It sits between the board switches and the HEX pins; the decoder becomes a pure glyph lookup behind it.

## Interface
- TICK_DIV, 25_000_000: clk cycles per scroll step (0.5 s at 50 MHz); legal ≥ 2.
- GAP, 2: blank positions appended after the word in each scroll pass; legal 0..7.
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  1  0 = manual, 1 = auto-cycle.
- sw_code  in  3  manual code {U,P,C}.
- code_sel  out  3  code driven to the word decoder.
- glyphs_in  in  42  decoder output; glyph k = bits [7k+6:7k], k=0 is rightmost character; active-high, bit6=a … bit0=g.
- HEX0..HEX5  out  7 each  active-low segment drives (per-bit inverted glyphs); 7'h7F = blank.
- busy  out  1  high in LOAD and SCROLL.
- pass_done  out  1  one-cycle pulse when the scroll pointer wraps.

## Operation
- States: IDLE, LOAD, SCROLL.
- IDLE: entered only on reset. Next cycle → LOAD with code_sel = sw_code (manual) or 3'b000 (auto).
- LOAD: lasts exactly 1 cycle, with code_sel stable. At its end:
  - glyph buffer gb[5:0] ← glyphs_in;
  - display shift register cleared to blank;
  - ptr ← 0; prescaler ← 0.
  - → SCROLL.
- Stream order: gb[5], gb[4], … gb[0], then GAP blanks. Length L = 6+GAP.
- SCROLL, on each tick:
  - HEX5←HEX4 … HEX1←HEX0, HEX0←stream[ptr];
  - ptr ← (ptr==L-1) ? 0 : ptr+1.
  - On the wrap, pass_done pulses in the same cycle as the shift.
- Auto advance: when pass_done fires and mode=1, code_sel advances to the next defined code and the block enters LOAD next cycle.
  - Order: 000→001→010→100→101→111→000.
  - Codes 011 and 110 are skipped.
- Manual mode:
  - sw_code is registered each cycle.
  - If it differs from code_sel while in SCROLL: code_sel ← new value, → LOAD next cycle, abandoning the scroll.
  - With no change, scrolling repeats indefinitely.
- Mode change:
  - auto→manual: treated as a manual code change; LOAD with sw_code next cycle.
  - manual→auto: takes effect at the next pass_done, advancing from the current code_sel to the next defined code. An undefined current code goes to 000.
- Simultaneous manual change and tick: the change wins. No shift occurs; → LOAD.
- The block never drives undefined codes in auto mode. In manual mode, undefined codes pass through and the decoder returns blanks.

## Timing
- Reset values: all HEXn = 7'h7F, code_sel = 3'b000, busy = 0, pass_done = 0, ptr = 0, prescaler = 0, state = IDLE.
- Reset asserted mid-scroll: all of the above apply at the next clk edge.
- Prescaler counts 0..TICK_DIV-1. tick = 1 in the cycle where the count equals TICK_DIV-1, then the count wraps to 0.
- First shift occurs TICK_DIV cycles after the LOAD cycle.
- code_sel → glyph capture latency: 1 cycle, which covers the decoder's combinational path.
- A full scroll pass takes L·TICK_DIV cycles. An auto-advance cycle takes L·TICK_DIV + 1 cycles (the extra cycle is LOAD).
- All outputs are registered. HEX outputs change only on tick or LOAD edges.

## Configuration
- HEXSEQ_STATIC_EN defined:
  - scrolling is removed;
  - LOAD writes gb directly to HEX5..HEX0 (inverted);
  - ptr still counts ticks and pass_done still pulses every L ticks, serving as a dwell timer for auto advance.
- Not defined: scrolling behaviour as described above.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, TICK_DIV=4, GAP=2 → all HEX = 7'h7F, busy=0. Release → LOAD on cycle 2, busy=1.
- Manual scroll: mode=0, sw_code=000, decoder glyphs G5..G0.
  - After 4 cycles: HEX0=~G5.
  - After 6 ticks: HEX5..HEX0 = ~G5..~G0.
  - pass_done on the 8th tick.
- Manual change mid-scroll: change sw_code 000→100 at tick 3 → code_sel=100 within 2 cycles, one LOAD cycle, HEX all 7'h7F, ptr=0.
- Auto cycling: mode=1, count pass_done pulses → code_sel sequence 000,001,010,100,101,111,000; never 011 or 110.
- Simultaneous tick and sw_code change → no shift, LOAD taken, ptr=0.
- With HEXSEQ_STATIC_EN, mode=1 → HEX equals inverted glyphs 1 cycle after LOAD; code advances every 8·TICK_DIV+1 cycles.

Source files
------------

// File: rtl/hex_word_sequencer.sv
// hex_word_sequencer
//   Sequencing controller for the six-digit HEX word display. It picks the
//   3-bit code that the external combinational word decoder evaluates, captures
//   the six glyphs that come back, and scrolls them right-to-left across
//   HEX5..HEX0, followed by GAP blank positions.
//   mode=0 (manual): the code follows sw_code, and a change reloads at once.
//   mode=1 (auto)  : after each full pass the code advances through the defined
//                    codes 000,001,010,100,101,111 and then wraps.
//
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   mode              0 = manual, 1 = auto-cycle
//   sw_code[2:0]      manual code {U,P,C}
//   code_sel[2:0]     code presented to the word decoder
//   glyphs_in[41:0]   decoder glyphs; glyph k = [7k+6:7k], k=0 is rightmost,
//                     active-high, bit6=a .. bit0=g
//   HEX0..HEX5[6:0]   active-low segment drives, 7'h7F = blank
//   busy              high in LOAD and SCROLL
//   pass_done         one-cycle pulse when the scroll pointer wraps
//
// Build option
//   HEXSEQ_STATIC_EN  when defined, no scrolling: LOAD writes the inverted
//                     glyphs straight to the digits, and ptr/pass_done act only
//                     as a dwell timer for auto advance.

// One display digit: a 7-bit register that either loads a value on LOAD or
// takes its right-hand neighbour's value on a scroll shift.
module hex_word_sequencer_digit #(
  parameter int VEC_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [VEC_W-1:0] ld_val,
  input  logic             sh,
  input  logic [VEC_W-1:0] sh_in,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset_n)  q <= '1;
    else if (ld)   q <= ld_val;
    else if (sh)   q <= sh_in;
  end
endmodule

module hex_word_sequencer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int GAP      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode,
  input  logic [2:0]  sw_code,
  output logic [2:0]  code_sel,
  input  logic [41:0] glyphs_in,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        busy,
  output logic        pass_done
);
  localparam int NUM_LANES = 6;
  localparam int VEC_W     = 7;
  localparam int L         = NUM_LANES + GAP;
  localparam int PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int QW        = 4;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  state_t                          state;
  logic [PW-1:0]                   presc;
  logic [QW-1:0]                   ptr;
  logic [2:0]                      sw_q;
  logic                            mode_q;
  logic                            tick;
  logic                            wrap;
  logic                            man_chg;
  logic                            ld_en;
  logic                            sh_en;
  logic [VEC_W-1:0]                stream;
  logic [NUM_LANES-1:0][VEC_W-1:0] gl;
  logic [NUM_LANES-1:0][VEC_W-1:0] hex_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] ld_val;
  logic [NUM_LANES-1:0][VEC_W-1:0] sh_in;

  assign gl   = glyphs_in;
  assign tick = (presc == PW'(TICK_DIV - 1));
  assign wrap = (ptr == QW'(L - 1));
  // Manual reload: the registered switches disagree with the current code, or
  // the mode has just dropped from auto to manual.
  assign man_chg = !mode && (mode_q || (sw_q != code_sel));
  assign ld_en   = (state == LOAD);

  // Auto order skips the undefined codes 011 and 110; anything not in the
  // list (including those two) restarts at 000.
  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b000:  next_code = 3'b001;
      3'b001:  next_code = 3'b010;
      3'b010:  next_code = 3'b100;
      3'b100:  next_code = 3'b101;
      3'b101:  next_code = 3'b111;
      default: next_code = 3'b000;
    endcase
  endfunction

`ifndef HEXSEQ_STATIC_EN
  logic [NUM_LANES-1:0][VEC_W-1:0] gb;

  // Stream position p < 6 is glyph gb[5-p]; the GAP positions after it blank.
  always_comb begin
    stream = '1;
    for (int k = 0; k < NUM_LANES; k++)
      if (ptr == QW'(NUM_LANES - 1 - k)) stream = ~gb[k];
  end

  // A manual change in the same cycle as a tick wins: no shift happens.
  assign sh_en = (state == SCROLL) && tick && !man_chg;
`else
  assign stream = '1;
  assign sh_en  = 1'b0;
`endif

  // Display lanes: lane 0 (HEX0) takes the stream, lane k takes lane k-1.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    if (k == 0) begin : g_head
      assign sh_in[k] = stream;
    end else begin : g_body
      assign sh_in[k] = hex_q[k-1];
    end
`ifdef HEXSEQ_STATIC_EN
    assign ld_val[k] = ~gl[k];
`else
    assign ld_val[k] = '1;
`endif
    hex_word_sequencer_digit #(.VEC_W(VEC_W)) u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .ld      (ld_en),
      .ld_val  (ld_val[k]),
      .sh      (sh_en),
      .sh_in   (sh_in[k]),
      .q       (hex_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      code_sel  <= 3'b000;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      ptr       <= '0;
      presc     <= '0;
      sw_q      <= sw_code;
      mode_q    <= mode;
`ifndef HEXSEQ_STATIC_EN
      gb        <= '0;
`endif
    end else begin
      sw_q      <= sw_code;
      mode_q    <= mode;
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          code_sel <= mode ? 3'b000 : sw_code;
          busy     <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          // code_sel has been stable for this whole cycle, so the decoder
          // output is settled and can be captured.
`ifndef HEXSEQ_STATIC_EN
          gb    <= gl;
`endif
          ptr   <= '0;
          presc <= '0;
          state <= SCROLL;
        end
        SCROLL: begin
          if (man_chg) begin
            code_sel <= sw_q;
            state    <= LOAD;
          end else if (tick) begin
            presc <= '0;
            ptr   <= wrap ? '0 : ptr + 1'b1;
            if (wrap) begin
              pass_done <= 1'b1;
              if (mode) begin
                code_sel <= next_code(code_sel);
                state    <= LOAD;
              end
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
endmodule
